pwm_slew_gen: RTL and testbench

- Sequences the signed 16-bit duty word produced by the PWM calculation stage into a physical PWM waveform.
- Provides soft-start, slew-limited tracking of the target, and soft-stop.
- Duty changes only at PWM period boundaries, so the output never glitches mid-period.
- Sits between the duty calculation block and the backlight/LED driver pin.

---
 rtl/pwm_slew_gen.sv | 173 +++++++++++++++++
 tb/tb_pwm_slew_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_slew_gen.sv
`default_nettype none
// ============================================================================
// Module      : pwm_slew_gen
// Description : Turns a signed duty request into a PWM waveform with
//               soft-start, slew-limited tracking and soft-stop. Duty and
//               state change only on PWM period boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_slew_gen #(
    parameter int PERIOD = 1000,
    parameter int STEP   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic signed [15:0] target,
    input  logic signed [15:0] pwm_max,
    input  logic signed [15:0] pwm_min,
    output logic               pwm_out,
    output logic signed [15:0] duty,
    output logic               period_strobe,
    output logic [1:0]         state,
    output logic               at_target
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_START = 2'd1,
        ST_TRACK = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic        [15:0] c_last_cnt = 16'(PERIOD - 1);
    localparam logic signed [16:0] c_step     = 17'(STEP);

    logic        [15:0] cnt_q, cnt_d;
    logic               strobe_q, strobe_d;
    state_t             state_q, state_d;
    logic signed [15:0] duty_q, duty_d;
    logic signed [15:0] tc_q, tc_d;
    logic               pwm_q, pwm_d;
    logic               at_target_q, at_target_d;

    logic               w_end;
    logic signed [15:0] w_t1;
    logic signed [15:0] w_tc;
    logic signed [15:0] w_slew_tc;
    logic signed [15:0] w_slew_min;
    logic        [15:0] w_de;

    // Move cur toward v by at most STEP; difference taken at 17 bits so
    // extreme operands cannot overflow.
    function automatic logic signed [15:0] slew(input logic signed [15:0] cur,
                                                input logic signed [15:0] v);
        logic signed [16:0] diff;
        diff = {v[15], v} - {cur[15], cur};
        if (diff > c_step) begin
            slew = cur + 16'(STEP);
        end else if (diff < -c_step) begin
            slew = cur - 16'(STEP);
        end else begin
            slew = v;
        end
    endfunction

    // Clamp the request into [pwm_min, pwm_max]; the upper limit is applied
    // last so it wins when the limits are inverted.
    always_comb begin
        w_t1       = (target < pwm_min) ? pwm_min : target;
        w_tc       = (w_t1 > pwm_max) ? pwm_max : w_t1;
        w_slew_tc  = slew(duty_q, w_tc);
        w_slew_min = slew(duty_q, pwm_min);
    end

    // Free-running period counter; the strobe flop is loaded from the next
    // count so it is high in the same cycle that cnt sits at its last value.
    always_comb begin
        w_end    = (cnt_q == c_last_cnt);
        cnt_d    = w_end ? 16'd0 : cnt_q + 16'd1;
        strobe_d = (cnt_d == c_last_cnt);
    end

    // Sequencer: inputs are sampled and duty/state updated only on the last
    // clock of a period, so every period uses a single duty value.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tc_d    = tc_q;
        if (w_end) begin
            tc_d = w_tc;
            case (state_q)
                ST_OFF: begin
                    duty_d = 16'sd0;
                    if (enable) begin
                        state_d = ST_START;
                        duty_d  = pwm_min;
                    end
                end
                ST_START: begin
                    if (!enable) begin
                        state_d = ST_STOP;
                        duty_d  = w_slew_min;
                    end else begin
                        duty_d = w_slew_tc;
                        if (w_slew_tc == w_tc) begin
                            state_d = ST_TRACK;
                        end
                    end
                end
                ST_TRACK: begin
                    if (!enable) begin
                        state_d = ST_STOP;
                        duty_d  = w_slew_min;
                    end else begin
                        duty_d = w_slew_tc;
                    end
                end
                ST_STOP: begin
                    if (enable) begin
                        state_d = ST_START;
                        duty_d  = w_slew_tc;
                    end else if (duty_q == pwm_min) begin
                        state_d = ST_OFF;
                        duty_d  = 16'sd0;
                    end else begin
                        duty_d = w_slew_min;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    duty_d  = 16'sd0;
                end
            endcase
        end
    end

    // Registered outputs are computed from next-cycle values so the waveform
    // and status line up with the period they describe.
    always_comb begin
        w_de        = duty_d[15] ? 16'd0 : 16'(duty_d);
        pwm_d       = (state_d != ST_OFF) && (w_de > cnt_d);
        at_target_d = (state_d == ST_TRACK) && (duty_d == tc_d);
    end

    // State registers with synchronous reset; reset drops straight to OFF.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= 16'd0;
            strobe_q    <= 1'b0;
            state_q     <= ST_OFF;
            duty_q      <= 16'sd0;
            tc_q        <= 16'sd0;
            pwm_q       <= 1'b0;
            at_target_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            strobe_q    <= strobe_d;
            state_q     <= state_d;
            duty_q      <= duty_d;
            tc_q        <= tc_d;
            pwm_q       <= pwm_d;
            at_target_q <= at_target_d;
        end
    end

    assign pwm_out       = pwm_q;
    assign duty          = duty_q;
    assign period_strobe = strobe_q;
    assign state         = state_q;
    assign at_target     = at_target_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_slew_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_slew_gen
// Description : Period-by-period bench for pwm_slew_gen (PERIOD=100, STEP=10).
//               Each table row holds the inputs for one period and the state,
//               duty and at_target expected in the following period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_slew_gen;

    localparam int PERIOD = 100;
    localparam int STEP   = 10;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic signed [15:0] target;
    logic signed [15:0] pwm_max;
    logic signed [15:0] pwm_min;
    logic               pwm_out;
    logic signed [15:0] duty;
    logic               period_strobe;
    logic [1:0]         state;
    logic               at_target;

    pwm_slew_gen #(.PERIOD(PERIOD), .STEP(STEP)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .target       (target),
        .pwm_max      (pwm_max),
        .pwm_min      (pwm_min),
        .pwm_out      (pwm_out),
        .duty         (duty),
        .period_strobe(period_strobe),
        .state        (state),
        .at_target    (at_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic en;
        int   tgt;
        int   mn;
        int   mx;
        int   st;
        int   dt;
        int   at;
    } vec_t;

    typedef struct {
        int st;
        int dt;
        int at;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input logic en, input int tgt, input int mn, input int mx,
                                input int st, input int dt, input int at);
        vec_t v;
        v.en = en; v.tgt = tgt; v.mn = mn; v.mx = mx;
        v.st = st; v.dt = dt; v.at = at;
        vecs.push_back(v);
    endfunction

    function automatic int exp_hi(input exp_t e);
        if (e.st == 0 || e.dt <= 0) return 0;
        if (e.dt >= PERIOD) return PERIOD;
        return e.dt;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Runs until the strobe edge (bounded), counting clocks and high cycles.
    task automatic step_period(output int cyc, output int hi);
        cyc = 0;
        hi  = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            @(negedge clk);
            cyc++;
            if (pwm_out) hi++;
            if (period_strobe) break;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_row(input int idx, input vec_t v);
        exp_t e;
        int   cyc;
        int   hi;
        enable  = v.en;
        target  = 16'(v.tgt);
        pwm_min = 16'(v.mn);
        pwm_max = 16'(v.mx);
        e.st = v.st; e.dt = v.dt; e.at = v.at;
        sb.push_back(e);
        step_period(cyc, hi);
        check($sformatf("row%0d period_len", idx), cyc, PERIOD);
        check($sformatf("row%0d pwm_high", idx), hi, exp_hi(cur));
        if (sb.size() == 0) begin
            check($sformatf("row%0d scoreboard_empty", idx), 0, 1);
        end else begin
            e = sb.pop_front();
            check($sformatf("row%0d state", idx), int'(state), e.st);
            check($sformatf("row%0d duty", idx), int'(duty), e.dt);
            check($sformatf("row%0d at_target", idx), int'(at_target), e.at);
            cur = e;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seg_a;
        int seg_b;

        rst     = 1'b1;
        enable  = 1'b0;
        target  = 16'sd0;
        pwm_min = 16'sd20;
        pwm_max = 16'sd80;

        // Soft-start to 60, slew up to clamp 80, down to floor 20, back to 60,
        // stop/restart mid-ramp, then full soft-stop into OFF.
        add(0, 60, 20, 80, 0, 0, 0);
        for (int d = 20; d <= 50; d += 10) add(1, 60, 20, 80, 1, d, 0);
        add(1, 60, 20, 80, 2, 60, 1);
        add(1, 60, 20, 80, 2, 60, 1);
        add(1, 200, 20, 80, 2, 70, 0);
        add(1, 200, 20, 80, 2, 80, 1);
        for (int d = 70; d >= 30; d -= 10) add(1, -5, 20, 80, 2, d, 0);
        add(1, -5, 20, 80, 2, 20, 1);
        for (int d = 30; d <= 50; d += 10) add(1, 60, 20, 80, 2, d, 0);
        add(1, 60, 20, 80, 2, 60, 1);
        add(0, 60, 20, 80, 3, 50, 0);
        add(0, 60, 20, 80, 3, 40, 0);
        add(1, 60, 20, 80, 1, 50, 0);
        add(1, 60, 20, 80, 2, 60, 1);
        for (int d = 50; d >= 20; d -= 10) add(0, 60, 20, 80, 3, d, 0);
        add(0, 60, 20, 80, 0, 0, 0);
        add(0, 60, 20, 80, 0, 0, 0);
        seg_a = vecs.size();

        // Inverted limits (upper wins, tc=30), then ramp beyond PERIOD to 120,
        // then stop one step and restart so the design sits in START.
        add(1, 50, 90, 30, 1, 90, 0);
        for (int d = 80; d >= 40; d -= 10) add(1, 50, 90, 30, 1, d, 0);
        add(1, 50, 90, 30, 2, 30, 1);
        for (int d = 40; d <= 110; d += 10) add(1, 120, 20, 150, 2, d, 0);
        add(1, 120, 20, 150, 2, 120, 1);
        add(0, 120, 20, 150, 3, 110, 0);
        add(1, 120, 20, 150, 1, 120, 0);
        seg_b = vecs.size();

        // Negative floor: duty below zero keeps the output low.
        add(1, -10, -10, 80, 1, -10, 0);
        add(1, -10, -10, 80, 2, -10, 1);
        add(0, -10, -10, 80, 3, -10, 0);
        add(0, -10, -10, 80, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("reset state", int'(state), 0);
        check("reset duty", int'(duty), 0);
        check("reset pwm_out", int'(pwm_out), 0);
        check("reset strobe", int'(period_strobe), 0);
        check("reset at_target", int'(at_target), 0);
        rst = 1'b0;
        cur.st = 0; cur.dt = 0; cur.at = 0;

        for (int i = 0; i < seg_a; i++) run_row(i, vecs[i]);

        // Pulse enable between strobes while OFF; only the strobe sample counts.
        begin
            vec_t v;
            v.en = 1'b0; v.tgt = 60; v.mn = 20; v.mx = 80;
            v.st = 0; v.dt = 0; v.at = 0;
            fork
                begin
                    repeat (20) @(posedge clk);
                    #1 enable = 1'b1;
                    repeat (20) @(posedge clk);
                    #1 enable = 1'b0;
                end
            join_none
            run_row(1000, v);
        end

        for (int i = seg_a; i < seg_b; i++) run_row(i, vecs[i]);

        // Reset in the middle of a START period with duty 120.
        repeat (30) @(posedge clk);
        #1;
        check("pre-reset pwm_out high", int'(pwm_out), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset state", int'(state), 0);
        check("midreset duty", int'(duty), 0);
        check("midreset pwm_out", int'(pwm_out), 0);
        check("midreset at_target", int'(at_target), 0);
        rst = 1'b0;
        cur.st = 0; cur.dt = 0; cur.at = 0;

        for (int i = seg_b; i < vecs.size(); i++) run_row(i, vecs[i]);

        check("scoreboard drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
